hall_sequence_generator: RTL and testbench
==========================================

# hall_sequence_generator

Produces the three-bit Hall sensor code that a rotating BLDC motor would present, stepping through the six valid commutation states at a programmable rate and direction. It is the transmitter end of the Hall interface: its `h` output drives the commutation decoder's Hall input in bench and bring-up builds, so the phase driver can run without a motor attached. It also provides a signed electrical-step position count and fault-code injection (000 / 111) for exercising the decoder's failure states.

## Interface
- `PERIOD_WIDTH`, 16, width of the step-period register and counter (clock cycles per Hall step).
- `POS_WIDTH`, 16, width of the signed electrical-step position counter.

- `clock` input 1, system clock; all state changes on its rising edge.
- `reset` input 1, asynchronous, active-high; clears all state immediately.
- `enable` input 1, when high the step counter advances; when low, all state holds.
- `direction` input 1, 0 = forward, 1 = reverse; sampled at each step.
- `step_period` input PERIOD_WIDTH, requested clock cycles per step; captured only on `load`.
- `load` input 1, single-cycle strobe; latches `step_period` into the period register.
- `fault` input 2, 00 = normal, 01 = force h=000, 10 = force h=111, 11 = treated as 00.
- `h` output 3, registered Hall code (h1,h2,h3).
- `step_strobe` output 1, registered one-cycle pulse coincident with each valid-sequence change of `h`.
- `position` output POS_WIDTH, registered signed step count; +1 per forward step, -1 per reverse step.
- `running` output 1, registered; high when `enable` is high, period register ≠ 0 and no fault is active.

## Operation
- Forward sequence, index 0..5: 101, 100, 110, 010, 011, 001, then back to 101.
- Reverse walks the same ring backwards: 101, 001, 011, 010, 110, 100.
- Only index values 0..5 are legal; the index wraps 5→0 going forward and 0→5 going reverse.
- Period register `per`: reset 0. On `load`, `per <= step_period`.
- `per == 0` means halted: no counting and no steps.
- Counting condition: `enable && per != 0 && fault` is normal (00 or 11).
- Each counting cycle:
  - If `count >= per-1`: `count <= 0`, the index advances per `direction`, `position` updates by ±1, and `step_strobe <= 1`.
  - Otherwise: `count <= count + 1`.
- `>=` is used so that loading a shorter period mid-step forces a step on the next counting cycle instead of an overflow.
- Non-counting cycles: `count`, index and `position` hold, and `step_strobe <= 0`.
- `position` wraps modulo 2^POS_WIDTH (two's complement); there is no saturation.
- `h` register: with fault 01 it is loaded with 000; with fault 10, with 111; otherwise with the code for the next index.
  - Removing a fault restores the held index's code on the next edge.
- `load` and a step in the same cycle: the step uses the old `per`; the new `per` applies from the next cycle.
  - `count` is not cleared by `load`.
- A `direction` change between steps takes effect at the next step; no extra step is inserted.
- Reset values (applied asynchronously, mid-operation included):
  - `h` = 101, `step_strobe` = 0, `position` = 0, `running` = 0, `count` = 0, index = 0, `per` = 0.

## Timing
- Steady state: one step every `per` counting cycles.
- `h` and `step_strobe` change on the same edge, which is the edge at which `count == per-1` is evaluated.
- Start-up, with `load` at edge 0 and `enable` high from edge 1: the first step appears after edge `per`, and then every `per` edges after that.
- `per = 1`: a step on every counting edge and `step_strobe` held high continuously. This is legal.
- Fault latency: `h` shows the fault code one edge after `fault` changes. Recovery to the sequence code takes one edge.
- `running` is registered from the counting condition, one edge late.
- Throughput is not limited beyond one step per cycle; there is no handshake.

## Test plan
- Reset then idle: `h` = 101, `position` = 0 and `step_strobe` = 0 for 20 cycles with `enable` = 1 and `per` = 0.
- Load 4, `enable`, forward: `h` changes 101→100→110→010→011→001→101, one change every 4 cycles. `step_strobe` pulses with each change; `position` reaches 6 after 24 cycles.
- Reverse with `per` = 2: `h` runs 101→001→011→010→110→100. `position` counts down to -6, then wraps: with POS_WIDTH = 4, stepping past -8 reads +7.
- Mid-step load: with `per` = 10 and `count` = 7, load 3. The step occurs on the next cycle, then every 3 cycles. `enable` low holds `h` and `count` exactly.
- Fault injection: fault 01 gives `h` = 000 one cycle later; fault 10 gives `h` = 111. `position` and the index are frozen during the fault, and clearing it restores the prior code.
- Asynchronous reset asserted mid-step, between edges: `h` goes to 101 and `position` to 0 before the next edge, and `per` = 0 keeps the generator halted afterwards.

Source files
------------

// File: rtl/hall_sequence_generator_if.sv
// Control and Hall-code bundle between a bench/bring-up master and the Hall sequence generator.
interface hall_sequence_generator_if #(
    parameter int unsigned PERIOD_WIDTH = 16,
    parameter int unsigned POS_WIDTH    = 16
);
    logic                    enable;
    logic                    direction;
    logic [PERIOD_WIDTH-1:0] step_period;
    logic                    load;
    logic [1:0]              fault;
    logic [2:0]              h;
    logic                    step_strobe;
    logic [POS_WIDTH-1:0]    position;
    logic                    running;

    // Side that programs the generator and observes the Hall code
    modport master (
        output enable,
        output direction,
        output step_period,
        output load,
        output fault,
        input  h,
        input  step_strobe,
        input  position,
        input  running
    );

    // The generator itself
    modport slave (
        input  enable,
        input  direction,
        input  step_period,
        input  load,
        input  fault,
        output h,
        output step_strobe,
        output position,
        output running
    );
endinterface

// File: rtl/hall_sequence_generator.sv
// Emulated BLDC Hall sensor: walks the six-state commutation ring at a programmable
// rate and direction, keeps a signed electrical-step count and can force 000/111 fault codes.
module hall_sequence_generator #(
    parameter int unsigned PERIOD_WIDTH = 16,
    parameter int unsigned POS_WIDTH    = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    hall_sequence_generator_if.slave bus
);
    localparam int unsigned IDX_WIDTH = 3;
    localparam logic [IDX_WIDTH-1:0] IDX_FIRST = IDX_WIDTH'(0);
    localparam logic [IDX_WIDTH-1:0] IDX_LAST  = IDX_WIDTH'(5);

    localparam logic [1:0] FAULT_LOW  = 2'b01;
    localparam logic [1:0] FAULT_HIGH = 2'b10;

    localparam logic [2:0] CODE_RESET = 3'b101;
    localparam logic [2:0] CODE_LOW   = 3'b000;
    localparam logic [2:0] CODE_HIGH  = 3'b111;

    logic [PERIOD_WIDTH-1:0] per;
    logic [PERIOD_WIDTH-1:0] count;
    logic [IDX_WIDTH-1:0]    idx;
    logic [POS_WIDTH-1:0]    pos;
    logic [2:0]              h_q;
    logic                    strobe_q;
    logic                    running_q;

    logic                    fault_active_c;
    logic                    counting_c;
    logic                    step_due_c;
    logic                    step_c;
    logic [IDX_WIDTH-1:0]    idx_adv_c;
    logic [IDX_WIDTH-1:0]    idx_next_c;
    logic [2:0]              h_next_c;

    // Hall code for each ring position, forward order 101,100,110,010,011,001
    function automatic logic [2:0] hall_code(input logic [IDX_WIDTH-1:0] i);
        logic [2:0] code;
        case (i)
            IDX_WIDTH'(0): code = 3'b101;
            IDX_WIDTH'(1): code = 3'b100;
            IDX_WIDTH'(2): code = 3'b110;
            IDX_WIDTH'(3): code = 3'b010;
            IDX_WIDTH'(4): code = 3'b011;
            IDX_WIDTH'(5): code = 3'b001;
            default:       code = CODE_RESET;
        endcase
        return code;
    endfunction

    // Fault decode and counting qualifier; fault 11 behaves like normal operation
    always_comb begin
        fault_active_c = (bus.fault == FAULT_LOW) || (bus.fault == FAULT_HIGH);
        counting_c     = bus.enable && (per != '0) && !fault_active_c;
    end

    // Step decision; >= lets a shorter period loaded mid-step fire immediately
    always_comb begin
        step_due_c = (count >= (per - PERIOD_WIDTH'(1)));
        step_c     = counting_c && step_due_c;
    end

    // Ring neighbour in the requested direction, wrapping 5<->0
    always_comb begin
        idx_adv_c = idx;
        if (bus.direction) begin
            if (idx == IDX_FIRST) begin
                idx_adv_c = IDX_LAST;
            end else begin
                idx_adv_c = idx - IDX_WIDTH'(1);
            end
        end else begin
            if (idx >= IDX_LAST) begin
                idx_adv_c = IDX_FIRST;
            end else begin
                idx_adv_c = idx + IDX_WIDTH'(1);
            end
        end
    end

    // Index after this edge, and the code the h register loads
    always_comb begin
        idx_next_c = step_c ? idx_adv_c : idx;
        h_next_c   = hall_code(idx_next_c);
        if (bus.fault == FAULT_LOW) begin
            h_next_c = CODE_LOW;
        end else if (bus.fault == FAULT_HIGH) begin
            h_next_c = CODE_HIGH;
        end
    end

    // Period register; a load coinciding with a step takes effect from the following cycle
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            per <= '0;
        end else if (bus.load) begin
            per <= bus.step_period;
        end
    end

    // Cycle counter within a step; held on non-counting cycles, untouched by load
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (counting_c) begin
            if (step_due_c) begin
                count <= '0;
            end else begin
                count <= count + PERIOD_WIDTH'(1);
            end
        end
    end

    // Ring index; frozen while halted, disabled or faulted
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            idx <= IDX_FIRST;
        end else begin
            idx <= idx_next_c;
        end
    end

    // Signed electrical-step position, wrapping modulo 2^POS_WIDTH
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            pos <= '0;
        end else if (step_c) begin
            if (bus.direction) begin
                pos <= pos - POS_WIDTH'(1);
            end else begin
                pos <= pos + POS_WIDTH'(1);
            end
        end
    end

    // Hall code, step pulse and running flag, all registered
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            h_q       <= CODE_RESET;
            strobe_q  <= 1'b0;
            running_q <= 1'b0;
        end else begin
            h_q       <= h_next_c;
            strobe_q  <= step_c;
            running_q <= counting_c;
        end
    end

    assign bus.h           = h_q;
    assign bus.step_strobe = strobe_q;
    assign bus.position    = pos;
    assign bus.running     = running_q;

endmodule

// File: tb/tb_hall_sequence_generator.sv
// Directed bench for hall_sequence_generator with a 4-bit position counter to reach the wrap.
module tb_hall_sequence_generator;
    localparam int unsigned PW = 16;
    localparam int unsigned QW = 4;

    logic clock = 1'b0;
    logic reset = 1'b0;

    int checks = 0;
    int errors = 0;

    logic [2:0] fwd [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    always #5 clock = ~clock;

    hall_sequence_generator_if #(.PERIOD_WIDTH(PW), .POS_WIDTH(QW)) bus ();

    hall_sequence_generator #(.PERIOD_WIDTH(PW), .POS_WIDTH(QW)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic expect_state(input string tag, input logic [2:0] eh, input logic es,
                                input logic [QW-1:0] ep);
        check({tag, ".h"}, 32'(bus.h), 32'(eh));
        check({tag, ".strobe"}, 32'(bus.step_strobe), 32'(es));
        check({tag, ".pos"}, 32'(bus.position), 32'(ep));
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    initial begin
        bus.enable      = 1'b0;
        bus.direction   = 1'b0;
        bus.step_period = '0;
        bus.load        = 1'b0;
        bus.fault       = 2'b00;

        // reset state
        #2 reset = 1'b1;
        #10;
        expect_state("reset", 3'b101, 1'b0, QW'(0));
        check("reset.running", 32'(bus.running), 32'd0);
        #1 reset = 1'b0;
        bus.enable = 1'b1;

        // idle with per = 0
        for (int i = 0; i < 20; i++) begin
            tick();
            expect_state("idle", 3'b101, 1'b0, QW'(0));
            check("idle.running", 32'(bus.running), 32'd0);
        end

        // forward, period 4
        bus.step_period = 16'd4;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        check("fwd.load_running", 32'(bus.running), 32'd0);
        for (int s = 1; s <= 6; s++) begin
            for (int k = 0; k < 3; k++) begin
                tick();
                expect_state("fwd.hold", fwd[(s - 1) % 6], 1'b0, QW'(s - 1));
                if (s == 1 && k == 0) check("fwd.running", 32'(bus.running), 32'd1);
            end
            tick();
            expect_state("fwd.step", fwd[s % 6], 1'b1, QW'(s));
        end

        // reverse, period 2, from a fresh async reset
        #3 reset = 1'b1;
        #2 reset = 1'b0;
        bus.step_period = 16'd2;
        bus.direction = 1'b1;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        expect_state("rev.load", 3'b101, 1'b0, QW'(0));
        for (int s = 1; s <= 9; s++) begin
            tick();
            expect_state("rev.hold", fwd[(6 - ((s - 1) % 6)) % 6], 1'b0, QW'(-(s - 1)));
            tick();
            expect_state("rev.step", fwd[(6 - (s % 6)) % 6], 1'b1, QW'(-s));
        end
        check("rev.wrap", 32'(bus.position), 32'd7);

        // mid-step load: per 10, count to 7, then load 3
        bus.enable = 1'b0;
        bus.direction = 1'b0;
        bus.step_period = 16'd10;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        check("mid.disabled_running", 32'(bus.running), 32'd0);
        bus.enable = 1'b1;
        for (int k = 0; k < 7; k++) begin
            tick();
            expect_state("mid.count", 3'b010, 1'b0, QW'(7));
        end
        bus.step_period = 16'd3;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        expect_state("mid.load_edge", 3'b010, 1'b0, QW'(7));
        tick();
        expect_state("mid.forced_step", 3'b011, 1'b1, QW'(8));
        tick();
        expect_state("mid.after1", 3'b011, 1'b0, QW'(8));
        tick();
        expect_state("mid.after2", 3'b011, 1'b0, QW'(8));
        tick();
        expect_state("mid.step3", 3'b001, 1'b1, QW'(9));
        tick();
        expect_state("mid.count1", 3'b001, 1'b0, QW'(9));

        // enable low holds h, position and count
        bus.enable = 1'b0;
        tick();
        check("hold.running", 32'(bus.running), 32'd0);
        for (int k = 0; k < 5; k++) begin
            tick();
            expect_state("hold", 3'b001, 1'b0, QW'(9));
        end
        bus.enable = 1'b1;
        tick();
        expect_state("hold.resume", 3'b001, 1'b0, QW'(9));
        check("hold.resume_running", 32'(bus.running), 32'd1);
        tick();
        expect_state("hold.step", 3'b101, 1'b1, QW'(10));

        // fault injection
        bus.fault = 2'b01;
        tick();
        expect_state("fault01", 3'b000, 1'b0, QW'(10));
        check("fault01.running", 32'(bus.running), 32'd0);
        for (int k = 0; k < 2; k++) begin
            tick();
            expect_state("fault01.hold", 3'b000, 1'b0, QW'(10));
        end
        bus.fault = 2'b10;
        tick();
        expect_state("fault10", 3'b111, 1'b0, QW'(10));
        tick();
        expect_state("fault10.hold", 3'b111, 1'b0, QW'(10));
        bus.fault = 2'b11;
        tick();
        expect_state("fault11", 3'b101, 1'b0, QW'(10));
        bus.fault = 2'b00;
        tick();
        expect_state("fault.clear", 3'b101, 1'b0, QW'(10));
        tick();
        expect_state("fault.step", 3'b100, 1'b1, QW'(11));

        // asynchronous reset between edges
        tick();
        expect_state("areset.pre", 3'b100, 1'b0, QW'(11));
        #3 reset = 1'b1;
        #1;
        expect_state("areset", 3'b101, 1'b0, QW'(0));
        check("areset.running", 32'(bus.running), 32'd0);
        #1 reset = 1'b0;
        for (int k = 0; k < 5; k++) begin
            tick();
            expect_state("areset.halted", 3'b101, 1'b0, QW'(0));
            check("areset.halted_running", 32'(bus.running), 32'd0);
        end

        // per = 1: step every edge, strobe held high
        bus.step_period = 16'd1;
        bus.load = 1'b1;
        tick();
        bus.load = 1'b0;
        expect_state("per1.load", 3'b101, 1'b0, QW'(0));
        for (int s = 1; s <= 7; s++) begin
            tick();
            expect_state("per1.step", fwd[s % 6], 1'b1, QW'(s));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
